computer: RTL and testbench

//  8-bit stored-program computer: accumulator CPU (regs A, B, PC, IR, MAR, CCR NZVC) plus 256-byte memory map.

---
 rtl/computer_pkg.sv | 56 +++++
 rtl/computer_memory.sv | 56 +++++
 rtl/computer.sv | 164 ++++++++++++++++
 tb/tb_computer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared definitions for the 8-bit accumulator computer.
// Holds the opcodes, address map, FSM states and built-in ROM image.
package computer_pkg;

   localparam logic [7:0] OP_LDA_IMM = 8'h86;
   localparam logic [7:0] OP_LDA_DIR = 8'h87;
   localparam logic [7:0] OP_LDB_IMM = 8'h88;
   localparam logic [7:0] OP_LDB_DIR = 8'h89;
   localparam logic [7:0] OP_STA_DIR = 8'h96;
   localparam logic [7:0] OP_STB_DIR = 8'h97;
   localparam logic [7:0] OP_ADD_AB  = 8'h42;
   localparam logic [7:0] OP_SUB_AB  = 8'h43;
   localparam logic [7:0] OP_AND_AB  = 8'h44;
   localparam logic [7:0] OP_OR_AB   = 8'h45;
   localparam logic [7:0] OP_INCA    = 8'h46;
   localparam logic [7:0] OP_INCB    = 8'h47;
   localparam logic [7:0] OP_DECA    = 8'h48;
   localparam logic [7:0] OP_DECB    = 8'h49;
   localparam logic [7:0] OP_BRA     = 8'h20;
   localparam logic [7:0] OP_BMI     = 8'h21;
   localparam logic [7:0] OP_BPL     = 8'h22;
   localparam logic [7:0] OP_BEQ     = 8'h23;
   localparam logic [7:0] OP_BNE     = 8'h24;
   localparam logic [7:0] OP_BVS     = 8'h25;
   localparam logic [7:0] OP_BVC     = 8'h26;
   localparam logic [7:0] OP_BCS     = 8'h27;
   localparam logic [7:0] OP_BCC     = 8'h28;

   localparam logic [7:0] RAM_BASE = 8'h80;
   localparam logic [7:0] OUT_BASE = 8'hE0;
   localparam logic [7:0] IN_BASE  = 8'hF0;

   typedef logic [127:0][7:0] rom_img_t;

   typedef enum logic [3:0] {
      FETCH_0, FETCH_1, FETCH_2, DECODE_3,
      OPND_4, OPND_5, OPND_6, MEM_7, LOAD_8,
      ALU_4, BR_4, BR_5, BR_6
   } state_t;

   function automatic rom_img_t builtin_rom();
      rom_img_t r;
      r = '0;
      r[0]  = OP_LDA_IMM; r[1]  = 8'hAA;
      r[2]  = OP_STA_DIR; r[3]  = 8'hE0;
      r[4]  = OP_LDB_IMM; r[5]  = 8'h01;
      r[6]  = OP_LDA_DIR; r[7]  = 8'hF0;
      r[8]  = OP_ADD_AB;
      r[9]  = OP_STA_DIR; r[10] = 8'hE1;
      r[11] = OP_BRA;     r[12] = 8'h00;
      return r;
   endfunction

   localparam rom_img_t BUILTIN_ROM = builtin_rom();

endpackage

// File: rtl/computer_memory.sv
// 256-byte memory map: ROM, RAM, output and input ports.
// Reads are registered one cycle after the address is presented.
module computer_memory
   import computer_pkg::*;
#(
   parameter rom_img_t ROM = BUILTIN_ROM
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] addr_i,
   input  logic       wr_en_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] rd_data_o,
   input  logic [7:0] port_in_i  [15:0],
   output logic [7:0] port_out_o [15:0]
);

   logic [7:0] ram_q [96];
   logic [7:0] out_q [15:0];
   logic [7:0] rd_d, rd_q;
   logic       is_ram, is_out;

   assign is_ram = (addr_i >= RAM_BASE) && (addr_i < OUT_BASE);
   assign is_out = (addr_i >= OUT_BASE) && (addr_i < IN_BASE);

   // RAM_BASE is 0x80, so the low seven address bits index RAM directly
   always_comb begin
      rd_d = port_in_i[addr_i[3:0]];
      if (addr_i < RAM_BASE)
         rd_d = ROM[addr_i[6:0]];
      else if (is_ram)
         rd_d = ram_q[addr_i[6:0]];
      else if (is_out)
         rd_d = out_q[addr_i[3:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         for (int i = 0; i < 96; i++)
            ram_q[i] <= '0;
         for (int i = 0; i < 16; i++)
            out_q[i] <= '0;
      end else begin
         rd_q <= rd_d;
         if (wr_en_i && is_ram)
            ram_q[addr_i[6:0]] <= wr_data_i;
         if (wr_en_i && is_out)
            out_q[addr_i[3:0]] <= wr_data_i;
      end
   end

   assign rd_data_o  = rd_q;
   assign port_out_o = out_q;

endmodule

// File: rtl/computer.sv
// Accumulator CPU (A, B, PC, IR, MAR, NZVC) with its memory map.
// ROM_FILE "" runs the built-in program; otherwise ROM_IMAGE holds the image.
module computer
   import computer_pkg::*;
#(
   parameter string    ROM_FILE  = "",
   parameter rom_img_t ROM_IMAGE = BUILTIN_ROM
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_in_data  [15:0],
   output logic [7:0] port_out_data [15:0]
);

   localparam rom_img_t ROM_SEL =
      (ROM_FILE == "") ? BUILTIN_ROM : ROM_IMAGE;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d, a_q, a_d, b_q, b_d;
   logic [7:0] ir_q, ir_d, mar_q, mar_d;
   logic [3:0] ccr_q, ccr_d;
   logic [7:0] from_mem, wr_data;
   logic       wr_en;

   computer_memory #(.ROM(ROM_SEL)) u_mem (
      .clk        (clk),
      .rst_n      (reset),
      .addr_i     (mar_q),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .rd_data_o  (from_mem),
      .port_in_i  (port_in_data),
      .port_out_o (port_out_data)
   );

   logic is_imm, is_st, is_b, is_mem, is_alu, is_br;
   assign is_imm = (ir_q == OP_LDA_IMM) || (ir_q == OP_LDB_IMM);
   assign is_st  = (ir_q == OP_STA_DIR) || (ir_q == OP_STB_DIR);
   assign is_b   = (ir_q == OP_LDB_IMM) || (ir_q == OP_LDB_DIR)
                || (ir_q == OP_STB_DIR);
   assign is_mem = is_imm || is_st || (ir_q == OP_LDA_DIR)
                || (ir_q == OP_LDB_DIR);
   assign is_alu = (ir_q >= OP_ADD_AB) && (ir_q <= OP_DECB);
   assign is_br  = (ir_q >= OP_BRA) && (ir_q <= OP_BCC);

   logic [7:0] x, y, lres, res;
   logic [8:0] sum;
   logic       sub, lg, dst_b, v;
   logic [3:0] flags;

   always_comb begin
      x = a_q; y = b_q;
      sub = 1'b0; lg = 1'b0; dst_b = 1'b0;
      lres = a_q & b_q;
      case (ir_q)
         OP_SUB_AB: sub = 1'b1;
         OP_AND_AB: lg = 1'b1;
         OP_OR_AB:  begin lg = 1'b1; lres = a_q | b_q; end
         OP_INCA:   y = 8'h01;
         OP_INCB:   begin x = b_q; y = 8'h01; dst_b = 1'b1; end
         OP_DECA:   begin y = 8'h01; sub = 1'b1; end
         OP_DECB:   begin
            x = b_q; y = 8'h01; sub = 1'b1; dst_b = 1'b1;
         end
         default: ;
      endcase
      // sum[8] is carry for add and borrow for subtract
      sum = sub ? ({1'b0, x} - {1'b0, y})
                : ({1'b0, x} + {1'b0, y});
      res = lg ? lres : sum[7:0];
      v   = ~lg && ((sub ? (x[7] != y[7]) : (x[7] == y[7]))
                    && (sum[7] != x[7]));
      flags = {res[7], res == 8'h00, v, ~lg & sum[8]};
   end

   logic taken;
   always_comb begin
      case (ir_q)
         OP_BRA:  taken = 1'b1;
         OP_BMI:  taken = ccr_q[3];
         OP_BPL:  taken = ~ccr_q[3];
         OP_BEQ:  taken = ccr_q[2];
         OP_BNE:  taken = ~ccr_q[2];
         OP_BVS:  taken = ccr_q[1];
         OP_BVC:  taken = ~ccr_q[1];
         OP_BCS:  taken = ccr_q[0];
         OP_BCC:  taken = ~ccr_q[0];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d = pc_q; a_d = a_q; b_d = b_q;
      ir_d = ir_q; mar_d = mar_q; ccr_d = ccr_q;
      wr_en = 1'b0;
      wr_data = is_b ? b_q : a_q;
      unique case (state_q)
         FETCH_0: begin mar_d = pc_q; state_d = FETCH_1; end
         FETCH_1: begin pc_d = pc_q + 8'h01; state_d = FETCH_2; end
         FETCH_2: begin ir_d = from_mem; state_d = DECODE_3; end
         DECODE_3: begin
            unique case (1'b1)
               is_mem:  state_d = OPND_4;
               is_alu:  state_d = ALU_4;
               is_br:   state_d = BR_4;
               default: state_d = FETCH_0;
            endcase
         end
         OPND_4: begin mar_d = pc_q; state_d = OPND_5; end
         OPND_5: begin pc_d = pc_q + 8'h01; state_d = OPND_6; end
         OPND_6: begin
            if (is_imm) begin
               if (is_b) b_d = from_mem;
               else      a_d = from_mem;
               state_d = FETCH_0;
            end else begin
               mar_d = from_mem;
               state_d = MEM_7;
            end
         end
         MEM_7: begin
            wr_en   = is_st;
            state_d = is_st ? FETCH_0 : LOAD_8;
         end
         LOAD_8: begin
            if (is_b) b_d = from_mem;
            else      a_d = from_mem;
            state_d = FETCH_0;
         end
         ALU_4: begin
            if (dst_b) b_d = res;
            else       a_d = res;
            ccr_d = flags;
            state_d = FETCH_0;
         end
         BR_4: begin
            if (taken) begin
               mar_d = pc_q;
               state_d = BR_5;
            end else begin
               pc_d = pc_q + 8'h01;
               state_d = FETCH_0;
            end
         end
         BR_5: state_d = BR_6;
         BR_6: begin pc_d = from_mem; state_d = FETCH_0; end
         default: state_d = FETCH_0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH_0;
         pc_q <= '0; a_q <= '0; b_q <= '0;
         ir_q <= '0; mar_q <= '0; ccr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d; a_q <= a_d; b_q <= b_d;
         ir_q <= ir_d; mar_q <= mar_d; ccr_q <= ccr_d;
      end
   end

endmodule

// File: tb/tb_computer.sv
// Directed bench: built-in program on dut, a custom ROM image on dut2.
// Expected values are hand-computed cycle counts and results.
module tb_computer;
   import computer_pkg::*;

   function automatic rom_img_t tb_rom();
      rom_img_t r;
      logic [0:44][7:0] p;
      p = {8'h86, 8'h7F, 8'h88, 8'h01, 8'h42, 8'h21, 8'h09,
           8'h96, 8'hE2, 8'h26, 8'h0D, 8'h96, 8'hE3, 8'h86,
           8'h00, 8'h48, 8'h27, 8'h14, 8'h96, 8'hE7, 8'h96,
           8'h80, 8'h89, 8'h80, 8'h97, 8'hE4, 8'h86, 8'h5A,
           8'h96, 8'hEF, 8'h86, 8'h00, 8'h87, 8'hEF, 8'h96,
           8'hE5, 8'h96, 8'h10, 8'h87, 8'h10, 8'h96, 8'hE6,
           8'hFF, 8'h20, 8'h2B};
      r = '0;
      for (int i = 0; i < 45; i++)
         r[i] = p[i];
      return r;
   endfunction

   localparam rom_img_t TB_ROM = tb_rom();

   logic       clk, rst1, rst2;
   logic [7:0] pin1 [15:0];
   logic [7:0] pin2 [15:0];
   logic [7:0] pout1 [15:0];
   logic [7:0] pout2 [15:0];
   int cyc, n_assert, n_fail;

   computer dut (
      .clk           (clk),
      .reset         (rst1),
      .port_in_data  (pin1),
      .port_out_data (pout1)
   );

   computer #(.ROM_FILE("prog2.hex"), .ROM_IMAGE(TB_ROM)) dut2 (
      .clk           (clk),
      .reset         (rst2),
      .port_in_data  (pin2),
      .port_out_data (pout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0;
      rst1 = 1'b0; rst2 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pin1[i] = 8'h00;
         pin2[i] = 8'h00;
      end
      pin1[0] = 8'h10;
      #12;
      check("rst_out0", pout1[0], 8'h00);
      check("rst_out15", pout1[15], 8'h00);
      check("rst_pc", dut.pc_q, 8'h00);
      check("rst_a", dut.a_q, 8'h00);

      @(negedge clk); rst1 = 1'b1; cyc = 0;
      run_to(14); check("t1_out0_c14", pout1[0], 8'h00);
      run_to(15); check("t1_out0_c15", pout1[0], 8'hAA);
      run_to(36); check("t1_ccr_c36", {4'h0, dut.ccr_q}, 8'h00);
      run_to(43); check("t1_out1_c43", pout1[1], 8'h00);
      run_to(44); check("t1_out1_c44", pout1[1], 8'h11);
      run_to(48); check("t1_out1_c48", pout1[1], 8'h11);
      pin1[0] = 8'h7F;
      run_to(87);
      check("t1_loop_a", dut.a_q, 8'h80);
      check("t1_loop_ccr", {4'h0, dut.ccr_q}, 8'h0A);
      run_to(95); check("t1_loop_out1", pout1[1], 8'h80);
      check("t1_loop_out0", pout1[0], 8'hAA);

      run_to(100);
      #2; rst1 = 1'b0; #1;
      check("t2_rst_out0", pout1[0], 8'h00);
      check("t2_rst_out1", pout1[1], 8'h00);
      check("t2_rst_pc", dut.pc_q, 8'h00);
      @(negedge clk); rst1 = 1'b1; cyc = 0;
      run_to(14); check("t2_out0_c14", pout1[0], 8'h00);
      run_to(15); check("t2_out0_c15", pout1[0], 8'hAA);
      run_to(43); check("t2_out1_c43", pout1[1], 8'h00);
      run_to(44); check("t2_out1_c44", pout1[1], 8'h80);

      @(negedge clk); rst2 = 1'b1; cyc = 0;
      run_to(19);
      check("t3_add_a", dut2.a_q, 8'h80);
      check("t3_add_ccr", {4'h0, dut2.ccr_q}, 8'h0A);
      run_to(26); check("t3_bmi_pc", dut2.pc_q, 8'h09);
      run_to(31); check("t3_bvc_pc", dut2.pc_q, 8'h0B);
      check("t3_bvc_ccr", {4'h0, dut2.ccr_q}, 8'h0A);
      run_to(38); check("t3_out3_c38", pout2[3], 8'h00);
      run_to(39); check("t3_out3_c39", pout2[3], 8'h80);
      run_to(51);
      check("t4_deca_a", dut2.a_q, 8'hFF);
      check("t4_deca_ccr", {4'h0, dut2.ccr_q}, 8'h09);
      run_to(58); check("t4_bcs_pc", dut2.pc_q, 8'h14);
      run_to(75); check("t4_ldb_dir_b", dut2.b_q, 8'hFF);
      run_to(83); check("t4_out4", pout2[4], 8'hFF);
      run_to(98); check("t5_out15", pout2[15], 8'h5A);
      run_to(114); check("t5_lda_ef", dut2.a_q, 8'h5A);
      run_to(122); check("t5_out5", pout2[5], 8'h5A);
      run_to(139); check("t5_rom_kept", dut2.a_q, 8'h27);
      run_to(146); check("t5_out6_c146", pout2[6], 8'h00);
      run_to(147); check("t5_out6_c147", pout2[6], 8'h27);
      run_to(151);
      check("t6_nop_pc", dut2.pc_q, 8'h2B);
      check("t6_nop_a", dut2.a_q, 8'h27);
      check("t6_nop_b", dut2.b_q, 8'hFF);
      check("t6_nop_ccr", {4'h0, dut2.ccr_q}, 8'h09);
      run_to(152); check("t6_pc_c152", dut2.pc_q, 8'h2B);
      run_to(153); check("t6_pc_c153", dut2.pc_q, 8'h2C);
      check("skip_bmi_out2", pout2[2], 8'h00);
      check("skip_bcs_out7", pout2[7], 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
